// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: nop encoding, fetch FSM
// states and the fetch buffer entry layout.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small fetch buffer holding fetched instruction/PC+4 pairs.
// DEPTH must be a power of two so the pointers wrap naturally.
// A clear has priority over push and pop.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_entry_t  wr_data,
  output fetch_entry_t  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointer and occupancy tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are masked by the consumer while empty
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, single-outstanding imem requests,
// fetch buffer and IF/ID presentation with stall/redirect handling.
// Optional macro IF_FETCH_PERF_EN adds fetch_cnt / bubble_cnt counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        enable_if_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        instr_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   pc;
  logic [31:0]   target_pc;
  logic          push;
  logic          pop;
  logic          room;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Buffer control and look-ahead occupancy used to reserve a slot for the in-flight word
  always_comb begin
    pop        = enable_if_id && !fifo_empty && !redirect;
    push       = (state == WAIT) && imem_ack && !redirect && (!fifo_full || pop);
    count_next = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
    room       = (count_next < CW'(FIFO_DEPTH));
    wr_entry   = '{instr: imem_rdata, pc4: pc + 32'd4};
  end

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clear   (redirect),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Fetch FSM with registered request outputs
  // An ack that leaves room re-issues at pc+4 directly (ISSUE folded into the same
  // edge) so a zero-wait memory sustains one instruction per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        ISSUE: begin
          if (redirect) begin
            pc <= target_pc;
          end else if (room) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc <= target_pc;
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= ISSUE;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            pc <= pc + 32'd4;
            if (room) begin
              imem_addr <= pc + 32'd4;
            end else begin
              imem_req <= 1'b0;
              state    <= ISSUE;
            end
          end
        end
        DISCARD: begin
          if (redirect) pc <= target_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ISSUE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ISSUE;
        end
      endcase
    end
  end

  assign instr_valid = !fifo_empty;
  assign instr_out   = fifo_empty ? NOP_INSTR : head.instr;
  assign pc4_out     = fifo_empty ? '0 : head.pc4;

`ifdef IF_FETCH_PERF_EN
  // Performance counters: words pushed and consumer-visible bubbles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (push) fetch_cnt <= fetch_cnt + 32'd1;
      if (enable_if_id && fifo_empty) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a random
// phase, checked against a queue-based model of the fetch stream.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        enable_if_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;
  logic        instr_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .enable_if_id (enable_if_id),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_out    (instr_out),
    .pc4_out      (pc4_out),
    .instr_valid  (instr_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          stale;
  int unsigned exp_fetch;
  int unsigned exp_bubble;
  int unsigned wcnt;
  int unsigned cur_lat;
  int          lat_mode;
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc     = 32'h0000_0000;
    stale      = 1'b0;
    exp_fetch  = 0;
    exp_bubble = 0;
    wcnt       = 0;
  endtask

  // Model of the fetch stream, evaluated with the inputs about to be sampled
  task automatic model_step();
    logic [31:0] rp;
    rp = {redirect_pc[31:2], 2'b00};
    if (enable_if_id && q.size() == 0) exp_bubble++;
    if (imem_req && imem_ack && !stale) check("fetch_addr", imem_addr, exp_pc);
    if (redirect) begin
      q.delete();
      exp_pc = rp;
      stale  = imem_req && !imem_ack;
    end else begin
      if (enable_if_id && q.size() != 0) void'(q.pop_front());
      if (imem_req && imem_ack) begin
        if (stale) stale = 1'b0;
        else begin
          q.push_back('{instr: mem_word(imem_addr), pc4: imem_addr + 32'd4});
          exp_pc = exp_pc + 32'd4;
          exp_fetch++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("instr_valid", {31'b0, instr_valid}, {31'b0, (q.size() != 0)});
    check("instr_out", instr_out, (q.size() != 0) ? q[0].instr : 32'h0);
    check("pc4_out", pc4_out, (q.size() != 0) ? q[0].pc4 : 32'h0);
    check("occupancy", q.size(), (q.size() <= 2) ? q.size() : 2);
  endtask

  // One clock: memory response, model update, edge, output check
  task automatic cycle();
    int unsigned wnext;
    if (imem_req && wcnt == 0)
      cur_lat = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
    imem_ack   = imem_req && (wcnt >= cur_lat);
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
    wnext      = (imem_req && imem_ack) ? 0 : (imem_req ? wcnt + 1 : 0);
    model_step();
    @(posedge clock);
    wcnt = wnext;
    #1;
    check_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instr_out, 32'h0);
    check({tag, "_pc4"}, pc4_out, 32'h0);
  endtask

  initial begin
    int unsigned n;
    int unsigned vcnt;
    reset_n      = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    enable_if_id = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    lat_mode     = 0;
    cur_lat      = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
`ifdef IF_FETCH_PERF_EN
    check("reset_fetch_cnt", fetch_cnt, 32'd0);
    check("reset_bubble_cnt", bubble_cnt, 32'd0);
`endif
    reset_n = 1'b1;

    // Zero-wait memory, consumer always ready: one instruction per cycle
    enable_if_id = 1'b1;
    cycle();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("valid_cycle1", {31'b0, instr_valid}, 32'h0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (instr_valid) vcnt++;
    end
    check("throughput", vcnt, 32'd10);
`ifdef IF_FETCH_PERF_EN
    // cycle 1,2 are bubbles; pushes at edges 2..11; redirect then one empty consume
    check("perf_fetch_10", fetch_cnt, 32'd10);
    check("perf_bubble_2", bubble_cnt, 32'd2);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    redirect = 1'b0;
    cycle();
    check("perf_fetch_cnt", fetch_cnt, 32'd10);
    check("perf_bubble_cnt", bubble_cnt, 32'd3);
`endif

    // Stall: buffer fills, request drops, head held
    enable_if_id = 1'b0;
    repeat (5) cycle();
    check("stall_req_drop", {31'b0, imem_req}, 32'h0);
    check("stall_full", q.size(), 32'd2);
    enable_if_id = 1'b1;
    repeat (8) cycle();

    // Redirect while a 3-wait request is pending
    lat_mode = 3;
    n = 0;
    while (!(imem_req && wcnt == 1) && n < 20) begin cycle(); n++; end
    check("pending_found", {31'b0, (imem_req && wcnt == 1)}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    check("discard_req_held", {31'b0, imem_req}, 32'h1);
    n = 0;
    while (!instr_valid && n < 30) begin cycle(); n++; end
    check("redir_pending_valid", {31'b0, instr_valid}, 32'h1);
    check("redir_pending_pc4", pc4_out, 32'h0000_0104);
    check("redir_pending_instr", instr_out, mem_word(32'h0000_0100));

    // Redirect on the same cycle as an ack (low bits of target ignored)
    lat_mode = 0;
    n = 0;
    while (!imem_req && n < 20) begin cycle(); n++; end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    check("redir_ack_empty", {31'b0, instr_valid}, 32'h0);
    check("redir_ack_req", {31'b0, imem_req}, 32'h0);
    cycle();
    check("redir_ack_req2", {31'b0, imem_req}, 32'h1);
    check("redir_ack_addr", imem_addr, 32'h0000_0100);
    repeat (4) cycle();

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();

    // Asynchronous reset in the middle of a wait
    lat_mode = 3;
    n = 0;
    while (!(imem_req && wcnt == 1) && n < 20) begin cycle(); n++; end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    lat_mode = 0;
    cycle();
    check("restart_addr", imem_addr, 32'h0000_0000);
    check("restart_req", {31'b0, imem_req}, 32'h1);

    // Random traffic: variable latency, stalls, redirects
    lat_mode = -1;
    for (int i = 0; i < 2000; i++) begin
      enable_if_id = ($urandom_range(0, 3) != 0);
      redirect     = ($urandom_range(0, 15) == 0);
      redirect_pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                 : $urandom();
      cycle();
    end
    redirect = 1'b0;
`ifdef IF_FETCH_PERF_EN
    check("rand_fetch_cnt", fetch_cnt, exp_fetch);
    check("rand_bubble_cnt", bubble_cnt, exp_bubble);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
